// File: rtl/dds_pkg.sv
// Shared definitions for the DDS-to-DAC SPI path: frame layout, FSM states
// and the 2's-complement to offset-binary conversion.
package dds_pkg;

    localparam int FRAME_W   = 24;
    localparam int CMD_W     = 4;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 16;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2,
        LOAD  = 2'd3
    } state_t;

    // Offset binary is the signed value plus half scale, i.e. MSB inverted.
    function automatic logic [DATA_W-1:0] to_offset(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/dds_spi_shifter.sv
// Serialises one 24-bit DAC word MSB first. SCLK is low for the first ClkDiv
// cycles of each bit and high for the second, so data is stable at the rise.
module dds_spi_shifter
    import dds_pkg::*;
#(
    parameter int ClkDiv = 2
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Start,
    input  logic [FRAME_W-1:0] Word,
    output logic               Done,
    output logic               SClk,
    output logic               SDI
);

    localparam logic [15:0]          PH_LAST  = 16'(ClkDiv - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0]   sreg;
    logic [15:0]          phase;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 active;
    logic                 phase_end;

    assign phase_end = (phase == PH_LAST);
    // Asserted during the final cycle of the last bit so the caller can
    // change state on the same edge that drops SCLK.
    assign Done      = active && SClk && phase_end && (bit_cnt == BIT_LAST);
    assign SDI       = sreg[FRAME_W-1];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sreg    <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            SClk    <= 1'b0;
        end else if (Start) begin
            sreg    <= Word;
            phase   <= '0;
            bit_cnt <= '0;
            active  <= 1'b1;
            SClk    <= 1'b0;
        end else if (active) begin
            if (phase_end) begin
                phase <= '0;
                SClk  <= ~SClk;
                if (SClk) begin
                    // falling edge: advance to next bit or finish
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                        sreg   <= '0;
                    end else begin
                        sreg    <= {sreg[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else begin
                phase <= phase + 16'd1;
            end
        end
    end

endmodule

// File: rtl/dds_dac_spi.sv
// Snapshots n DDS channel samples on Strobe and writes them to a multi-channel
// SPI DAC, one frame per channel, then pulses nLDAC to update all outputs.
module dds_dac_spi
    import dds_pkg::*;
#(
    parameter int                n       = 12,
    parameter int                ClkDiv  = 2,
    parameter logic [CMD_W-1:0]  Command = 4'b0000
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [DATA_W*n-1:0]   Data,
    input  logic                  Strobe,
    output logic                  Busy,
    output logic                  Overrun,
    output logic                  DAC_nCS,
    output logic                  DAC_SClk,
    output logic                  DAC_SDI,
    output logic                  DAC_nLDAC
);

    if (n < 1 || n > 16) begin : g_bad_n
        $error("dds_dac_spi: n must be in 1..16");
    end
    if (ClkDiv < 1) begin : g_bad_div
        $error("dds_dac_spi: ClkDiv must be >= 1");
    end

    localparam logic [15:0]       WAIT_LAST = 16'(2 * ClkDiv - 1);
    localparam logic [ADDR_W-1:0] CH_LAST   = ADDR_W'(n - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   ch, ch_d;
    logic [DATA_W-1:0]   shadow [n];
    logic [DATA_W-1:0]   sel_data;
    logic [15:0]         wait_cnt;
    logic                wait_last;
    logic                latch;
    logic                start;
    logic                done;
    logic [FRAME_W-1:0]  word;

    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_d;
            ch    <= ch_d;
        end
    end

    always_comb begin
        state_d = state;
        ch_d    = ch;
        latch   = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (Strobe) begin
                    latch   = 1'b1;
                    start   = 1'b1;
                    ch_d    = '0;
                    state_d = FRAME;
                end
            end
            FRAME: begin
                if (done) state_d = GAP;
            end
            GAP: begin
                if (wait_last) begin
                    if (ch == CH_LAST) begin
                        state_d = LOAD;
                    end else begin
                        ch_d    = ch + 1'b1;
                        start   = 1'b1;
                        state_d = FRAME;
                    end
                end
            end
            LOAD: begin
                if (wait_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < n; i++) begin
            if (ch_d == ADDR_W'(i)) sel_data = shadow[i];
        end
    end

    // Channel 0's word comes straight from Data on the latch cycle so its MSB
    // is on SDI in the first busy cycle; later words come from the shadows.
    assign word = latch ? {Command, {ADDR_W{1'b0}}, to_offset(Data[DATA_W-1:0])}
                        : {Command, ch_d, sel_data};

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < n; i++) shadow[i] <= '0;
        end else if (latch) begin
            for (int i = 0; i < n; i++) shadow[i] <= to_offset(Data[DATA_W*i +: DATA_W]);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wait_cnt <= '0;
        end else if (state_d != state) begin
            wait_cnt <= '0;
        end else if (state == GAP || state == LOAD) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Pins are registered from the next state so they align with it.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Busy      <= 1'b0;
            Overrun   <= 1'b0;
            DAC_nCS   <= 1'b1;
            DAC_nLDAC <= 1'b1;
        end else begin
            Busy      <= (state_d != IDLE);
            Overrun   <= Strobe && (state != IDLE);
            DAC_nCS   <= (state_d != FRAME);
            DAC_nLDAC <= (state_d != LOAD);
        end
    end

    dds_spi_shifter #(
        .ClkDiv (ClkDiv)
    ) u_shifter (
        .Clk    (Clk),
        .nReset (nReset),
        .Start  (start),
        .Word   (word),
        .Done   (done),
        .SClk   (DAC_SClk),
        .SDI    (DAC_SDI)
    );

endmodule
